// File: rtl/pe_cfg_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pe_cfg_loader
// Purpose  : Context loader in front of one PE. Clears the PE, streams a
//            context of instruction words from configuration SRAM into it
//            with init pulses, then drives run for exactly one pass.
// Options  : PE_CFG_LOADER_PARITY_EN - mem_rdata carries an even-parity MSB;
//            a bad word aborts the load (PE reset + err pulse).
// Revision : 1.0 - initial release
// ============================================================================
module pe_cfg_loader #(
  parameter int INST_W = 28,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] ctx_base,
  input  logic [LEN_W-1:0]  ctx_len,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
`ifdef PE_CFG_LOADER_PARITY_EN
  input  logic [INST_W:0]   mem_rdata,
`else
  input  logic [INST_W-1:0] mem_rdata,
`endif
  output logic              pe_rst,
  output logic [INST_W-1:0] pe_inst,
  output logic              pe_init,
  output logic              pe_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] base_q,     base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LEN_W-1:0]  len_q,      len_d;
  logic [LEN_W-1:0]  rd_cnt_q,   rd_cnt_d;    // reads issued so far
  logic [LEN_W-1:0]  run_cnt_q,  run_cnt_d;   // run cycles scheduled so far
  logic              mem_en_q,   mem_en_d;
  logic              pe_rst_q,   pe_rst_d;
  logic              init_q,     init_d;      // SRAM word returns this cycle
  logic              run_q,      run_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;
  logic              abort;

  // A word with bad parity is detected in the cycle it returns and acts
  // immediately: it must never reach the PE, so the abort is combinational.
`ifdef PE_CFG_LOADER_PARITY_EN
  assign abort = (state_q == S_LOAD) && init_q &&
                 (mem_rdata[INST_W] != (^mem_rdata[INST_W-1:0]));
`else
  assign abort = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      mem_addr_q <= '0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      run_cnt_q  <= '0;
      mem_en_q   <= 1'b0;
      pe_rst_q   <= 1'b0;
      init_q     <= 1'b0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      mem_addr_q <= mem_addr_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      run_cnt_q  <= run_cnt_d;
      mem_en_q   <= mem_en_d;
      pe_rst_q   <= pe_rst_d;
      init_q     <= init_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-output logic; every output flop is computed one
  // cycle ahead so the ports come straight from registers.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    mem_addr_d = mem_addr_q;
    rd_cnt_d   = rd_cnt_q;
    run_cnt_d  = run_cnt_q;
    mem_en_d   = 1'b0;
    pe_rst_d   = 1'b0;
    init_d     = 1'b0;
    run_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((ctx_len == '0) || (ctx_len > MAX_LEN)) begin
            err_d = 1'b1;
          end else begin
            base_d   = ctx_base;
            len_d    = ctx_len;
            pe_rst_d = 1'b1;
            busy_d   = 1'b1;
            state_d  = S_CLR;
          end
        end
      end

      S_CLR: begin
        mem_en_d   = 1'b1;
        mem_addr_d = base_q;
        rd_cnt_d   = LEN_W'(1);
        state_d    = S_LOAD;
      end

      S_LOAD: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          // Data comes back one cycle after each read.
          init_d = mem_en_q;
          if (mem_en_q && (rd_cnt_q != len_q)) begin
            mem_en_d   = 1'b1;
            mem_addr_d = mem_addr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
            rd_cnt_d   = rd_cnt_q + LEN_W'(1);
          end
          // Last word is being delivered and no read is outstanding.
          if (!mem_en_q && init_q) begin
            run_d     = 1'b1;
            run_cnt_d = LEN_W'(1);
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (run_cnt_q != len_q) begin
          run_d     = 1'b1;
          run_cnt_d = run_cnt_q + LEN_W'(1);
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The SRAM output is already a register, so the word is forwarded in its
  // return cycle, gated to zero whenever it is not being written to the PE.
  assign mem_en   = mem_en_q & ~abort;
  assign mem_addr = mem_addr_q;
  assign pe_init  = init_q & ~abort;
  assign pe_inst  = pe_init ? mem_rdata[INST_W-1:0] : '0;
  assign pe_rst   = pe_rst_q | abort;
  assign pe_run   = run_q;
  assign busy     = busy_q & ~abort;
  assign done     = done_q;
  assign err      = err_q | abort;

endmodule
`default_nettype wire

// File: tb/tb_pe_cfg_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pe_cfg_loader
// Purpose  : Self-checking bench for pe_cfg_loader: table of directed
//            transactions checked cycle by cycle against the timing
//            expected from a start, plus reset and parity-abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_cfg_loader;

  localparam int INST_W = 28;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 5;
`ifdef PE_CFG_LOADER_PARITY_EN
  localparam int RD_W = INST_W + 1;
`else
  localparam int RD_W = INST_W;
`endif
  localparam int VW = 1 + ADDR_W + 1 + INST_W + 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] ctx_base = '0;
  logic [LEN_W-1:0]  ctx_len = '0;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [RD_W-1:0]   mem_rdata = '0;
  logic              pe_rst;
  logic [INST_W-1:0] pe_inst;
  logic              pe_init;
  logic              pe_run;
  logic              busy;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] bad_addr = '0;
  logic              bad_addr_en = 1'b0;

  pe_cfg_loader #(
    .INST_W(INST_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ctx_base(ctx_base), .ctx_len(ctx_len),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pe_rst(pe_rst), .pe_inst(pe_inst), .pe_init(pe_init), .pe_run(pe_run),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // SRAM contents: a scrambled function of the address.
  function automatic logic [INST_W-1:0] word_at(input logic [ADDR_W-1:0] a);
    logic [31:0] h;
    h = ({22'd0, a} * 32'h0001_3579) ^ 32'h0ABC_DEF1;
    return h[INST_W-1:0];
  endfunction

  // Synchronous-read SRAM model: data valid the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
`ifdef PE_CFG_LOADER_PARITY_EN
      mem_rdata <= {(^word_at(mem_addr)) ^ (bad_addr_en && (mem_addr == bad_addr)),
                    word_at(mem_addr)};
`else
      mem_rdata <= word_at(mem_addr);
`endif
    end
  end

  function automatic logic [VW-1:0] pack(input logic en, input logic [ADDR_W-1:0] addr,
                                         input logic prst, input logic [INST_W-1:0] inst,
                                         input logic init, input logic run, input logic bsy,
                                         input logic dn, input logic er);
    return {en, addr, prst, inst, init, run, bsy, dn, er};
  endfunction

  // Actual outputs; the address is ignored while no read is issued.
  function automatic logic [VW-1:0] act_vec(input bit mask_addr);
    logic [ADDR_W-1:0] a;
    a = (mask_addr && !mem_en) ? '0 : mem_addr;
    return pack(mem_en, a, pe_rst, pe_inst, pe_init, pe_run, busy, done, err);
  endfunction

  // Expected outputs c cycles after an accepted start.
  function automatic logic [VW-1:0] exp_at(input logic [ADDR_W-1:0] base, input int len,
                                           input int c);
    logic en, init, run, bsy;
    logic [ADDR_W-1:0] a, wa;
    logic [INST_W-1:0] inst;
    en   = (c >= 2) && (c <= 1 + len);
    a    = base + ADDR_W'(c - 2);
    wa   = base + ADDR_W'(c - 3);
    init = (c >= 3) && (c <= 2 + len);
    inst = init ? word_at(wa) : '0;
    run  = (c >= 3 + len) && (c <= 2 + 2 * len);
    bsy  = (c >= 1) && (c <= 2 + 2 * len);
    return pack(en, en ? a : '0, c == 1, inst, init, run, bsy, c == 3 + 2 * len, 1'b0);
  endfunction

  task automatic check(input string name, input int c, input logic [VW-1:0] exp,
                       input logic [VW-1:0] act);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, c, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
    @(posedge clk); #1;
    start = 1'b1; ctx_base = base; ctx_len = len;
    @(posedge clk); #1;
    start = 1'b0; ctx_base = '0; ctx_len = LEN_W'(1);
  endtask

  // One transaction checked every cycle; pa/pb are cycles in which a stray
  // (valid) start is pulsed and must be ignored.
  task automatic run_txn(input string name, input logic [ADDR_W-1:0] base,
                         input logic [LEN_W-1:0] len, input bit reject,
                         input int pa, input int pb);
    int n;
    int l;
    logic [VW-1:0] e;
    l = int'(len);
    n = reject ? 3 : 2 * l + 5;
    pulse_start(base, len);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (reject) e = pack(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, c == 1);
      else        e = exp_at(base, l, c);
      check(name, c, e, act_vec(1'b1));
      if (c == pa || c == pb) start = 1'b1;
    end
  endtask

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    bit                reject;
    int                poke_a;
    int                poke_b;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [VW-1:0] zero;
    zero = pack(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    vecs[0] = '{"basic_len3",   10'h010, 5'd3,  1'b0, 0, 0};
    vecs[1] = '{"reject_len0",  10'h010, 5'd0,  1'b1, 0, 0};
    vecs[2] = '{"reject_len17", 10'h010, 5'd17, 1'b1, 0, 0};
    vecs[3] = '{"wrap_len2",    10'h3FF, 5'd2,  1'b0, 0, 0};
    vecs[4] = '{"full_depth",   10'h3F8, 5'd16, 1'b0, 0, 0};
    vecs[5] = '{"start_busy",   10'h020, 5'd4,  1'b0, 4, 9};
    vecs[6] = '{"len1",         10'h200, 5'd1,  1'b0, 0, 0};

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", 0, zero, act_vec(1'b0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].name, vecs[i].base, vecs[i].len, vecs[i].reject,
              vecs[i].poke_a, vecs[i].poke_b);
    end

    // Reset at the second run cycle of a len=3 load.
    pulse_start(10'h010, 5'd3);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check("pre_rst", c, exp_at(10'h010, 3, c), act_vec(1'b1));
      if (c == 7) rst = 1'b1;
    end
    @(negedge clk);
    check("rst_clear", 8, zero, act_vec(1'b0));
    rst = 1'b0;
    run_txn("after_rst", 10'h010, 5'd3, 1'b0, 0, 0);

`ifdef PE_CFG_LOADER_PARITY_EN
    // Word 2 of 4 carries a flipped parity bit.
    bad_addr    = 10'h102;
    bad_addr_en = 1'b1;
    pulse_start(10'h100, 5'd4);
    for (int c = 1; c <= 12; c++) begin
      logic [VW-1:0] e;
      @(negedge clk);
      if (c <= 4)       e = exp_at(10'h100, 4, c);
      else if (c == 5)  e = pack(1'b0, '0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      else              e = zero;
      check("parity_abort", c, e, act_vec(1'b1));
    end
    bad_addr_en = 1'b0;
    run_txn("after_abort", 10'h100, 5'd4, 1'b0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
